// File: rtl/mem_req_bridge_if.sv
`default_nettype none
// ============================================================================
// mem_req_bridge_if : CPU-side bus cycle and controller request signals
// Revision 1.0
// ============================================================================
interface mem_req_bridge_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16
);
   logic                  cpu_req;
   logic                  cpu_rw;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_wdata;
   logic                  cpu_rdy;
   logic                  cpu_done;
   logic [DATA_WIDTH-1:0] cpu_rdata;
   logic                  cpu_err;
   logic                  mem_busy;
   logic                  mem_rd_en;
   logic                  mem_wr_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Environment side: CPU core plus memory controller
   modport master (
      output cpu_req, cpu_rw, cpu_addr, cpu_wdata, mem_busy, mem_rdata,
      input  cpu_rdy, cpu_done, cpu_rdata, cpu_err,
             mem_rd_en, mem_wr_en, mem_addr, mem_wdata
   );

   // Bridge side
   modport slave (
      input  cpu_req, cpu_rw, cpu_addr, cpu_wdata, mem_busy, mem_rdata,
      output cpu_rdy, cpu_done, cpu_rdata, cpu_err,
             mem_rd_en, mem_wr_en, mem_addr, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_req_bridge.sv
`default_nettype none
// ============================================================================
// mem_req_bridge : one-at-a-time 6502 bus cycle to memory controller request
// Optional busy timeout: MEM_REQ_BRIDGE_TIMEOUT_EN.  Revision 1.0
// ============================================================================
module mem_req_bridge #(
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    ADDR_WIDTH     = 16,
   parameter int                    RD_LATENCY     = 2,
   parameter int                    TIMEOUT_CYCLES = 1024,
   parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(8'hFF)
) (
   input  wire logic        clk,
   input  wire logic        reset,
   mem_req_bridge_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_DATA = 3'd2,
      DONE      = 3'd3,
      ERR       = 3'd4
   } state_t;

   localparam logic [3:0] c_LAT = 4'(RD_LATENCY);

   if ((RD_LATENCY < 1) || (RD_LATENCY > 15) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
      $error("mem_req_bridge: RD_LATENCY must be 1..15 and TIMEOUT_CYCLES >= 1");
   end

   state_t                state_q;
   logic                  rw_q;
   logic [3:0]            lat_cnt_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  rdy_q;
   logic                  done_q;
   logic                  err_q;

   logic w_accept;
   logic w_issue;
   logic w_timeout;

   assign w_accept = bus.cpu_req && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
   // Enables are gated by reset so nothing reaches the controller while it is held
   assign w_issue  = reset && (state_q == ISSUE) && !bus.mem_busy;

`ifdef MEM_REQ_BRIDGE_TIMEOUT_EN
   localparam int c_BUSY_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [c_BUSY_W-1:0] busy_cnt_q;

   // Fires in the busy cycle whose increment would reach the limit; a ready cycle issues instead
   assign w_timeout = (state_q == ISSUE) && bus.mem_busy &&
                      (busy_cnt_q == c_BUSY_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         busy_cnt_q <= '0;
      end else if (w_accept) begin
         busy_cnt_q <= '0;
      end else if ((state_q == ISSUE) && bus.mem_busy) begin
         busy_cnt_q <= busy_cnt_q + c_BUSY_W'(1);
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         rw_q      <= 1'b0;
         lat_cnt_q <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         rdy_q     <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE, DONE, ERR: begin
               if (w_accept) begin
                  rw_q    <= bus.cpu_rw;
                  addr_q  <= bus.cpu_addr;
                  wdata_q <= bus.cpu_wdata;
                  rdy_q   <= 1'b0;
                  state_q <= ISSUE;
               end else begin
                  rdy_q   <= 1'b1;
                  state_q <= IDLE;
               end
            end
            ISSUE: begin
               if (!bus.mem_busy) begin
                  lat_cnt_q <= 4'd1;
                  if (rw_q) begin
                     state_q <= WAIT_DATA;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     rdy_q   <= 1'b1;
                  end
               end else if (w_timeout) begin
                  state_q <= ERR;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  rdy_q   <= 1'b1;
                  rdata_q <= ERR_DATA;
               end
            end
            WAIT_DATA: begin
               // lat_cnt_q equals k during cycle t+k; it stops at the compare point
               if (lat_cnt_q == c_LAT) begin
                  rdata_q <= bus.mem_rdata;
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  rdy_q   <= 1'b1;
               end else begin
                  lat_cnt_q <= lat_cnt_q + 4'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               rdy_q   <= 1'b1;
            end
         endcase
      end
   end

   assign bus.cpu_rdy   = rdy_q;
   assign bus.cpu_done  = done_q;
   assign bus.cpu_rdata = rdata_q;
   assign bus.cpu_err   = err_q;
   assign bus.mem_rd_en = w_issue && rw_q;
   assign bus.mem_wr_en = w_issue && !rw_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

endmodule
`default_nettype wire
